burst_initiator: RTL and testbench

- Initiator side of the burst SRAM interface. It accepts one burst command (direction, base address, stride, beat count) and sequences the per-beat SRAM strobes and addresses.
- Write bursts: streams write data in from a valid/ready source.
- Read bursts: returns read data with a valid strobe, aligned to the SRAM read latency.
- Sits between a requesting client and the sram instance, in place of the client driving raw wren/rden/addr.

---
 rtl/burst_initiator.sv | 140 ++++++++++++++
 tb/tb_burst_initiator.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_initiator.sv
// Burst SRAM initiator: takes one burst command and sequences per-beat SRAM
// strobes, addresses and data for write and read bursts.
module burst_initiator #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int STRIDE_LEN = 2,
  parameter int LEN_WIDTH  = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [STRIDE_LEN-1:0] cmd_stride,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  rdata_valid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  done,
  output logic                  err,
  output logic                  mem_wren,
  output logic                  mem_rden,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_WIDTH-1:0]  beats_left_q, beats_left_d;
  logic [STRIDE_LEN-1:0] stride_q, stride_d;
  logic                  err_flag_q, err_flag_d;
  logic [RD_LATENCY-1:0] vpipe_q, vpipe_d;
  logic [DATA_WIDTH-1:0] rdata_hold_q, rdata_hold_d;
  logic [ADDR_WIDTH:0]   next_addr;
  logic                  beat_fire;

  // One extra bit catches the carry out of the address space.
  assign next_addr = {1'b0, cur_addr_q} + ({{ADDR_WIDTH{1'b0}}, 1'b1} << stride_q);

  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    beats_left_d = beats_left_q;
    stride_d     = stride_q;
    err_flag_d   = err_flag_q;
    vpipe_d      = vpipe_q << 1;
    beat_fire    = 1'b0;
    cmd_ready    = 1'b0;
    wdata_ready  = 1'b0;
    mem_wren     = 1'b0;
    mem_rden     = 1'b0;
    mem_addr     = '0;
    mem_wr_data  = '0;
    done         = 1'b0;
    err          = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cur_addr_d   = cmd_addr;
          beats_left_d = cmd_len;
          stride_d     = cmd_stride;
          err_flag_d   = 1'b0;
          state_d      = cmd_write ? WRITE : READ;
        end
      end
      WRITE: begin
        wdata_ready = 1'b1;
        mem_wren    = wdata_valid;
        mem_addr    = cur_addr_q;
        mem_wr_data = wdata;
        beat_fire   = wdata_valid;
      end
      READ: begin
        mem_rden   = 1'b1;
        mem_addr   = cur_addr_q;
        beat_fire  = 1'b1;
        vpipe_d[0] = 1'b1;
      end
      DRAIN: begin
        // Leave once the return currently at the pipe output is the last one.
        if (vpipe_d == '0) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        err     = err_flag_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (beat_fire) begin
      if (beats_left_q == '0) begin
        state_d = (state_q == WRITE) ? DONE : DRAIN;
      end else if (next_addr[ADDR_WIDTH]) begin
        err_flag_d = 1'b1;
        state_d    = (state_q == WRITE) ? DONE : DRAIN;
      end else begin
        cur_addr_d   = next_addr[ADDR_WIDTH-1:0];
        beats_left_d = beats_left_q - 1'b1;
      end
    end
  end

  // Read data passes straight through on a valid return and is held after.
  always_comb begin
    rdata_valid  = vpipe_q[RD_LATENCY-1];
    rdata        = rdata_valid ? mem_rd_data : rdata_hold_q;
    rdata_hold_d = rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cur_addr_q   <= '0;
      beats_left_q <= '0;
      stride_q     <= '0;
      err_flag_q   <= 1'b0;
      vpipe_q      <= '0;
      rdata_hold_q <= '0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      beats_left_q <= beats_left_d;
      stride_q     <= stride_d;
      err_flag_q   <= err_flag_d;
      vpipe_q      <= vpipe_d;
      rdata_hold_q <= rdata_hold_d;
    end
  end

endmodule

// File: tb/tb_burst_initiator.sv
// Directed self-checking bench for burst_initiator: one instance with read
// latency 1 on a behavioural SRAM, one with latency 3 for the mid-burst reset.
module tb_burst_initiator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rst2;
  logic       cmd_valid, cmd_valid2, cmd_write;
  logic [7:0] cmd_addr;
  logic [1:0] cmd_stride;
  logic [3:0] cmd_len;
  logic       wdata_valid;
  logic [7:0] wdata;

  logic       cmd_ready, wdata_ready, rdata_valid, done, err, mem_wren, mem_rden;
  logic [7:0] rdata, mem_addr, mem_wr_data, mem_rd_data;
  logic       cmd_ready2, wdata_ready2, rdata_valid2, done2, err2, mem_wren2, mem_rden2;
  logic [7:0] rdata2, mem_addr2, mem_wr_data2, mem_rd_data2;

  int checks = 0;
  int errors = 0;

  burst_initiator #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .STRIDE_LEN(2), .LEN_WIDTH(4), .RD_LATENCY(1)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_stride(cmd_stride), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata(rdata), .done(done), .err(err),
    .mem_wren(mem_wren), .mem_rden(mem_rden), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  burst_initiator #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .STRIDE_LEN(2), .LEN_WIDTH(4), .RD_LATENCY(3)) dut2 (
    .clk(clk), .rst(rst2), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_stride(cmd_stride), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready2), .wdata(wdata),
    .rdata_valid(rdata_valid2), .rdata(rdata2), .done(done2), .err(err2),
    .mem_wren(mem_wren2), .mem_rden(mem_rden2), .mem_addr(mem_addr2),
    .mem_wr_data(mem_wr_data2), .mem_rd_data(mem_rd_data2)
  );

  // Behavioural SRAM with a one-cycle registered read
  logic [7:0] mem [256];
  logic [7:0] mem_rd_q;
  always @(posedge clk) begin
    if (mem_wren) mem[mem_addr] <= mem_wr_data;
    if (mem_rden) mem_rd_q <= mem[mem_addr];
  end
  assign mem_rd_data = mem_rd_q;

  // Three-stage read return for the second instance; data is address-derived
  logic [7:0] rp2 [3];
  always @(posedge clk) begin
    rp2[0] <= mem_rden2 ? (mem_addr2 ^ 8'h5A) : 8'h00;
    rp2[1] <= rp2[0];
    rp2[2] <= rp2[1];
  end
  assign mem_rd_data2 = rp2[2];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not reach the end, errors so far %0d", errors);
    $fatal(1);
  end

  task automatic test_reset();
    logic [31:0] obs, expv;
    repeat (2) @(posedge clk);
    #1;
    obs  = {25'd0, cmd_ready, wdata_ready, rdata_valid, done, err, mem_wren, mem_rden};
    expv = {25'd0, 7'b1000000};
    checks++;
    if (obs !== expv) begin errors++; $display("[TB] FAIL reset_flags: got %h expected %h", obs, expv); end
    obs  = {8'd0, rdata, mem_addr, mem_wr_data};
    expv = 32'd0;
    checks++;
    if (obs !== expv) begin errors++; $display("[TB] FAIL reset_buses: got %h expected %h", obs, expv); end
    obs  = {25'd0, cmd_ready2, wdata_ready2, rdata_valid2, done2, err2, mem_wren2, mem_rden2};
    expv = {25'd0, 7'b1000000};
    checks++;
    if (obs !== expv) begin errors++; $display("[TB] FAIL reset2_flags: got %h expected %h", obs, expv); end
    obs  = {8'd0, rdata2, mem_addr2, mem_wr_data2};
    expv = 32'd0;
    checks++;
    if (obs !== expv) begin errors++; $display("[TB] FAIL reset2_buses: got %h expected %h", obs, expv); end
    rst  = 1'b0;
    rst2 = 1'b0;
  endtask

  task automatic test_write_basic();
    logic [31:0] obs, expv;
    logic [7:0]  ea, ed;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h10; cmd_stride = 2'd0; cmd_len = 4'd3;
    wdata_valid = 1'b1; wdata = 8'hA0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL wr_accept_ready: got %b expected 1", cmd_ready); end
    for (int i = 0; i < 4; i++) begin
      ea = 8'(8'h10 + i);
      ed = 8'(8'hA0 + i);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      wdata = ed;
      @(negedge clk);
      obs  = {13'd0, mem_wren, wdata_ready, cmd_ready, mem_addr, mem_wr_data};
      expv = {13'd0, 1'b1, 1'b1, 1'b0, ea, ed};
      checks++;
      if (obs !== expv) begin errors++; $display("[TB] FAIL wr_beat%0d: got %h expected %h", i, obs, expv); end
    end
    @(posedge clk); #1;
    wdata_valid = 1'b0;
    @(negedge clk);
    obs  = {28'd0, done, err, mem_wren, cmd_ready};
    expv = {28'd0, 4'b1000};
    checks++;
    if (obs !== expv) begin errors++; $display("[TB] FAIL wr_done: got %h expected %h", obs, expv); end
    @(posedge clk); #1;
    @(negedge clk);
    obs  = {30'd0, done, cmd_ready};
    expv = {30'd0, 2'b01};
    checks++;
    if (obs !== expv) begin errors++; $display("[TB] FAIL wr_back_idle: got %h expected %h", obs, expv); end
  endtask

  task automatic test_read_basic();
    logic [31:0] obs, expv;
    logic [7:0]  ea, er;
    logic        erden, erv, edone;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h10; cmd_stride = 2'd0; cmd_len = 4'd3;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      erden = (c <= 4);
      ea    = (c <= 4) ? 8'(8'h10 + c - 1) : 8'h00;
      erv   = (c >= 2) && (c <= 5);
      if (c == 1)      er = 8'h00;
      else if (c <= 5) er = 8'(8'hA0 + c - 2);
      else             er = 8'hA3;
      edone = (c == 6);
      @(negedge clk);
      obs  = {12'd0, mem_rden, mem_addr, rdata_valid, rdata, done, err};
      expv = {12'd0, erden, ea, erv, er, edone, 1'b0};
      checks++;
      if (obs !== expv) begin errors++; $display("[TB] FAIL rd_cycle%0d: got %h expected %h", c, obs, expv); end
    end
  endtask

  task automatic test_write_stall();
    logic [31:0] obs, expv;
    logic       vtab [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [7:0] dtab [7] = '{8'hB0, 8'hEE, 8'hEE, 8'hEE, 8'hB1, 8'hB2, 8'hEE};
    logic [7:0] edtab [7] = '{8'hB0, 8'hEE, 8'hEE, 8'hEE, 8'hB1, 8'hB2, 8'h00};
    logic [7:0] eatab [7] = '{8'h20, 8'h24, 8'h24, 8'h24, 8'h24, 8'h28, 8'h00};
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h20; cmd_stride = 2'd2; cmd_len = 4'd2;
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      wdata_valid = vtab[c];
      wdata = dtab[c];
      @(negedge clk);
      obs  = {12'd0, mem_wren, wdata_ready, done, err, mem_addr, mem_wr_data};
      expv = {12'd0, vtab[c], (c < 6) ? 1'b1 : 1'b0, (c == 6) ? 1'b1 : 1'b0, 1'b0, eatab[c], edtab[c]};
      checks++;
      if (obs !== expv) begin errors++; $display("[TB] FAIL stall_cycle%0d: got %h expected %h", c + 1, obs, expv); end
    end
    wdata_valid = 1'b0;
  endtask

  task automatic test_overflow();
    logic [31:0] obs, expv;
    logic [7:0]  a0, a1, d0, d1;
    logic        seen, errv;
    int          nw, nr, nv;
    a0 = 8'h00; a1 = 8'h00; d0 = 8'h00; d1 = 8'h00;
    seen = 1'b0; errv = 1'b0; nw = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'hF8; cmd_stride = 2'd2; cmd_len = 4'd7;
    wdata_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      wdata = 8'(8'hC0 + nw);
      @(negedge clk);
      if (mem_wren) begin
        if (nw == 0) a0 = mem_addr;
        if (nw == 1) a1 = mem_addr;
        nw++;
      end
      if (done) begin seen = 1'b1; errv = err; break; end
    end
    wdata_valid = 1'b0;
    obs  = {30'd0, seen, errv};
    expv = 32'd3;
    checks++;
    if (obs !== expv) begin errors++; $display("[TB] FAIL ovf_wr_done_err: got %h expected %h", obs, expv); end
    obs  = {8'(nw), a0, a1, 8'd0};
    expv = {8'd2, 8'hF8, 8'hFC, 8'd0};
    checks++;
    if (obs !== expv) begin errors++; $display("[TB] FAIL ovf_wr_beats: got %h expected %h", obs, expv); end

    a0 = 8'h00; a1 = 8'h00; seen = 1'b0; errv = 1'b0; nr = 0; nv = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'hF8; cmd_stride = 2'd2; cmd_len = 4'd7;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(negedge clk);
      if (mem_rden) begin
        if (nr == 0) a0 = mem_addr;
        if (nr == 1) a1 = mem_addr;
        nr++;
      end
      if (rdata_valid) begin
        if (nv == 0) d0 = rdata;
        if (nv == 1) d1 = rdata;
        nv++;
      end
      if (done) begin seen = 1'b1; errv = err; break; end
    end
    obs  = {30'd0, seen, errv};
    expv = 32'd3;
    checks++;
    if (obs !== expv) begin errors++; $display("[TB] FAIL ovf_rd_done_err: got %h expected %h", obs, expv); end
    obs  = {8'(nr), a0, a1, 8'd0};
    expv = {8'd2, 8'hF8, 8'hFC, 8'd0};
    checks++;
    if (obs !== expv) begin errors++; $display("[TB] FAIL ovf_rd_issues: got %h expected %h", obs, expv); end
    obs  = {8'(nv), d0, d1, 8'd0};
    expv = {8'd2, 8'hC0, 8'hC1, 8'd0};
    checks++;
    if (obs !== expv) begin errors++; $display("[TB] FAIL ovf_rd_returns: got %h expected %h", obs, expv); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] obs, expv;
    logic       rtab [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       wtab [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic       dtab [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] atab [8] = '{8'h00, 8'h40, 8'h41, 8'h00, 8'h00, 8'h40, 8'h41, 8'h00};
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h40; cmd_stride = 2'd0; cmd_len = 4'd1;
        wdata_valid = 1'b1; wdata = 8'h55;
      end
      if (c == 7) cmd_valid = 1'b0;
      @(negedge clk);
      obs  = {21'd0, cmd_ready, mem_wren, done, mem_addr};
      expv = {21'd0, rtab[c], wtab[c], dtab[c], atab[c]};
      checks++;
      if (obs !== expv) begin errors++; $display("[TB] FAIL b2b_cycle%0d: got %h expected %h", c, obs, expv); end
    end
    @(posedge clk); #1;
    wdata_valid = 1'b0;
    @(negedge clk);
    obs  = {29'd0, cmd_ready, mem_wren, done};
    expv = {29'd0, 3'b100};
    checks++;
    if (obs !== expv) begin errors++; $display("[TB] FAIL b2b_no_third: got %h expected %h", obs, expv); end
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] obs, expv;
    int          late;
    @(posedge clk); #1;
    cmd_valid2 = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h30; cmd_stride = 2'd0; cmd_len = 4'd7;
    for (int c = 1; c <= 2; c++) begin
      @(posedge clk); #1;
      cmd_valid2 = 1'b0;
      @(negedge clk);
      obs  = {22'd0, mem_rden2, rdata_valid2, mem_addr2};
      expv = {22'd0, 1'b1, 1'b0, 8'(8'h30 + c - 1)};
      checks++;
      if (obs !== expv) begin errors++; $display("[TB] FAIL rst_pre_cycle%0d: got %h expected %h", c, obs, expv); end
    end
    @(posedge clk); #1;
    rst2 = 1'b1;
    #1;
    obs  = {1'b0, cmd_ready2, wdata_ready2, rdata_valid2, done2, err2, mem_wren2, mem_rden2,
            rdata2, mem_addr2, mem_wr_data2};
    expv = {1'b0, 7'b1000000, 24'd0};
    checks++;
    if (obs !== expv) begin errors++; $display("[TB] FAIL rst_immediate: got %h expected %h", obs, expv); end
    @(posedge clk); #1;
    rst2 = 1'b0;
    late = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rdata_valid2 || done2 || mem_rden2) late++;
      @(posedge clk); #1;
    end
    obs  = {late[30:0], cmd_ready2};
    expv = 32'd1;
    checks++;
    if (obs !== expv) begin errors++; $display("[TB] FAIL rst_after_quiet: got %h expected %h", obs, expv); end
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    cmd_valid = 1'b0; cmd_valid2 = 1'b0; cmd_write = 1'b0;
    cmd_addr = 8'h00; cmd_stride = 2'd0; cmd_len = 4'd0;
    wdata_valid = 1'b0; wdata = 8'h00;
    $display("[TB] starting burst_initiator bench");
    test_reset();
    test_write_basic();
    test_read_basic();
    test_write_stall();
    test_overflow();
    test_back_to_back();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
